alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
// - Shares one combinational 32-bit ALU between NREQ requesters (e.g. execute stage, branch compare, multdiv sequencer).
// - Round-robin arbitration, per-requester valid/ready request and response handshakes.
// - Drives registered ALU operands/opcode and captures the ALU result into a held response register.
// - Exactly one transaction in flight at a time.
// PARAMETERS
// - NREQ  2   number of requesters (2..8)
// - WIDTH 32  operand/result width
// - OPW   5   ALU opcode width
// PORTS
// - clock       in   1          single clock, rising edge
// - reset       in   1          asynchronous, active-high; clears all state
// - req_valid   in   NREQ       requester i holds a request
// - req_ready   out  NREQ       one-hot grant; request i accepted on clock edge when valid&ready
// - req_op      in   NREQ*OPW   opcode of requester i, slice [i*OPW +: OPW]
// - req_a       in   NREQ*WIDTH operand A, slice [i*WIDTH +: WIDTH]
// - req_b       in   NREQ*WIDTH operand B, slice [i*WIDTH +: WIDTH]
// - resp_valid  out  NREQ       one-hot; response for requester i present
// - resp_ready  in   NREQ       requester i takes response
// - resp_data   out  WIDTH      shared result bus, meaningful only while any resp_valid
// - resp_err    out  1          opcode was illegal; qualifies resp_data (forced 0)
// - alu_op      out  OPW        registered opcode to ALU
// - alu_a       out  WIDTH      registered operand A to ALU
// - alu_b       out  WIDTH      registered operand B to ALU
// - alu_result  in   WIDTH      combinational ALU result of alu_op/alu_a/alu_b
// BEHAVIOUR
// - Reset values: req_ready=0, resp_valid=0, resp_data=0, resp_err=0, alu_op/a/b=0, state=IDLE, rr pointer=0.
// - FSM IDLE -> EXEC -> RESP -> IDLE.
// - IDLE: if |req_valid, winner = first valid index at or after pointer (cyclic).
//   - req_ready[winner]=1 combinationally in this cycle only; all other req_ready=0.
//   - At the edge: latch winner op/a/b into alu_* regs, record owner, legality flag; go to EXEC.
//   - No valid: stay IDLE, req_ready=0.
// - EXEC: one cycle; capture alu_result into resp_data (0 if illegal) and set resp_err; go to RESP.
// - RESP: resp_valid[owner]=1 until resp_ready[owner]; then resp_valid=0, pointer=owner+1 mod NREQ, go to IDLE.
//   - resp_ready of non-owners ignored.
// - Latency: grant edge -> resp_valid = 2 cycles; minimum 3 cycles per transaction (no back-to-back).
// - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready; valid held until accepted.
// - Legal opcodes: 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 SLL, 00101 SRA; all others illegal, ALU still driven.
// - Pointer updates only on response completion, so a requester stalling its response blocks all others (intended).
// - alu_* regs hold last value outside EXEC; not cleared on completion.
// - Reset mid-transaction: transaction dropped silently, no response issued, pointer returns to 0.
// - Simultaneous requests: pointer gives priority; ties impossible (single winner).
// STRUCTURE
// - Package alu_arb_pkg: opcode localparams (OP_ADD..OP_SRA), state encoding (IDLE/EXEC/RESP), op_legal function.
// - Sub-module rr_arbiter #(NREQ): inputs req vector and pointer, outputs one-hot grant and binary index; combinational.
// - Top: FSM, operand/owner/result registers, pointer register, output decode.
// TESTING
// - Reset: assert reset mid-EXEC with owner 1 -> all outputs 0 async, no resp_valid after release, pointer=0.
// - Single req: req0 AND a=0xF0F0_F0F0 b=0xFF00_FF00 -> req_ready[0] 1 cycle, resp_valid[0] 2 cycles later, resp_data=0xF000_F000.
// - Contention: both valid from reset -> req0 served first, then req1 (ADD 5+7 -> 12); then both again -> req0 again (rotation).
// - Backpressure: hold resp_ready[1]=0 for 10 cycles while req0 valid -> resp_valid[1] and resp_data stable, req_ready[0]=0 throughout.
// - Illegal op 01111 on req1 -> resp_err=1, resp_data=0, pointer still advances.
// - Random: 1000 mixed requests vs reference model -> results, order and one-hot invariants all match.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU share arbiter: opcode values, controller
// state encoding and the opcode legality check.
package alu_arb_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_AND = 5'b00010;
  localparam logic [4:0] OP_OR  = 5'b00011;
  localparam logic [4:0] OP_SLL = 5'b00100;
  localparam logic [4:0] OP_SRA = 5'b00101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Legal opcodes form the contiguous range ADD..SRA.
  function automatic logic op_legal(input logic [31:0] op);
    return op <= 32'(OP_SRA);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after the
// pointer, wrapping to the lowest requesting index overall.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] hi_req;
  logic [NREQ-1:0] sel;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi_mask[i] = (IW'(i) >= ptr_i);
    end
    hi_req = req_i & hi_mask;
    sel    = (|hi_req) ? hi_req : req_i;
  end

  // Descending scan so the lowest set bit of sel wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
        idx_o      = IW'(i);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NREQ requesters with round-robin
// arbitration; one transaction in flight, result held until taken.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*OPW-1:0]   req_op,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic                  resp_err,
  output logic [OPW-1:0]        alu_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  input  logic [WIDTH-1:0]      alu_result
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             legal_q, legal_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;

  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    win_idx;
  logic             any_req;
  logic [NREQ-1:0]  owner_oh;
  logic [OPW-1:0]   win_op;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_req)
  );

  always_comb begin
    win_op = '0;
    win_a  = '0;
    win_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_op = req_op[i*OPW +: OPW];
        win_a  = req_a[i*WIDTH +: WIDTH];
        win_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    legal_d     = legal_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d  = ST_EXEC;
          owner_d  = win_idx;
          alu_op_d = win_op;
          alu_a_d  = win_a;
          alu_b_d  = win_b;
          legal_d  = op_legal(32'(win_op));
        end
      end
      ST_EXEC: begin
        resp_data_d = legal_q ? alu_result : '0;
        resp_err_d  = !legal_q;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        // Pointer only moves on completion, so a stalled owner blocks everyone.
        if (|(resp_ready & owner_oh)) begin
          state_d = ST_IDLE;
          ptr_d   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      legal_q     <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      legal_q     <= legal_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Grant is gated by reset so no request can look accepted while held in reset.
  assign req_ready  = (state_q == ST_IDLE && !reset) ? grant : '0;
  assign resp_valid = (state_q == ST_RESP) ? owner_oh : '0;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign alu_op     = alu_op_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic compared cycle by cycle against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int OW = 5;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op = '0;
  logic [N*W-1:0]  req_a = '0;
  logic [N*W-1:0]  req_b = '0;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '0;
  logic [W-1:0]    resp_data;
  logic            resp_err;
  logic [OW-1:0]   alu_op;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    alu_result;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter #(.NREQ(N), .WIDTH(W), .OPW(OW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always #5 clock = ~clock;

  // Reference ALU; illegal opcodes yield a nonzero pattern so forcing to 0 is visible.
  function automatic logic [W-1:0] ref_alu(input logic [OW-1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << b[4:0];
      5'd5:    return W'($signed(a) >>> b[4:0]);
      default: return a ^ b ^ 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_result = ref_alu(alu_op, alu_a, alu_b);

  function automatic bit bit_of(input logic [N-1:0] v, input int idx);
    return ((v >> idx) & N'(1)) != '0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester agent (sole driver of request/response inputs)
  int            post_seq[N]  = '{default: 0};
  int            taken_seq[N] = '{default: 0};
  logic [OW-1:0] post_op[N];
  logic [W-1:0]  post_a[N];
  logic [W-1:0]  post_b[N];
  bit            rand_mode = 1'b0;
  logic [N-1:0]  dir_rr = '1;
  logic [N-1:0]  acc;

  always begin
    @(negedge clock);
    acc = req_valid & req_ready;
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) req_valid[i] = 1'b0;
      if (!req_valid[i]) begin
        if (post_seq[i] != taken_seq[i]) begin
          req_op[i*OW +: OW] = post_op[i];
          req_a[i*W +: W]    = post_a[i];
          req_b[i*W +: W]    = post_b[i];
          req_valid[i]       = 1'b1;
          taken_seq[i]       = post_seq[i];
        end else if (rand_mode && $urandom_range(0, 2) == 0) begin
          req_op[i*OW +: OW] = ($urandom_range(0, 7) == 0) ? OW'($urandom)
                                                            : OW'($urandom_range(0, 5));
          req_a[i*W +: W]    = $urandom;
          req_b[i*W +: W]    = ($urandom_range(0, 1) == 1) ? $urandom : W'($urandom_range(0, 40));
          req_valid[i]       = 1'b1;
        end
      end
    end
    resp_ready = rand_mode ? N'($urandom) : dir_rr;
  end

  // ---------------- transaction-level model and per-cycle compare
  bit            m_busy  = 1'b0;
  int            m_age   = 0;
  int            m_owner = 0;
  int            m_ptr   = 0;
  logic [W-1:0]  m_data  = '0;
  logic          m_err   = 1'b0;
  logic [OW-1:0] m_op    = '0;
  logic [W-1:0]  m_a     = '0;
  logic [W-1:0]  m_b     = '0;
  int            done_cnt = 0;

  always @(negedge clock) begin : model
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    int           win;
    if (reset) begin
      m_busy = 1'b0;
      m_age  = 0;
      m_ptr  = 0;
      m_op   = '0;
      m_a    = '0;
      m_b    = '0;
    end else begin
      exp_ready = '0;
      exp_rv    = '0;
      win       = -1;
      if (!m_busy) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && bit_of(req_valid, (m_ptr + k) % N)) win = (m_ptr + k) % N;
        if (win >= 0) exp_ready = N'(1) << win;
      end else if (m_age >= 2) begin
        exp_rv = N'(1) << m_owner;
      end
      chk("req_ready", req_ready, exp_ready);
      chk("resp_valid", resp_valid, exp_rv);
      chk("req_ready_onehot", $onehot0(req_ready), 1);
      chk("resp_valid_onehot", $onehot0(resp_valid), 1);
      if (m_busy && m_age >= 2) begin
        chk("resp_data", resp_data, m_data);
        chk("resp_err", resp_err, m_err);
      end
      chk("alu_op", alu_op, m_op);
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      if (!m_busy) begin
        if (win >= 0) begin
          m_busy  = 1'b1;
          m_age   = 1;
          m_owner = win;
          m_op    = OW'(req_op >> (win * OW));
          m_a     = W'(req_a >> (win * W));
          m_b     = W'(req_b >> (win * W));
          m_err   = !(m_op <= 5'd5);
          m_data  = m_err ? '0 : ref_alu(m_op, m_a, m_b);
        end
      end else if (m_age >= 2 && bit_of(resp_ready, m_owner)) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % N;
        done_cnt++;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- directed helpers
  task automatic post(input int i, input logic [OW-1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b);
    post_op[i] = op;
    post_a[i]  = a;
    post_b[i]  = b;
    post_seq[i]++;
  endtask

  task automatic wait_resp(input string name, output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (resp_valid != '0) begin
        idx = resp_valid[1] ? 1 : 0;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL %s: no resp_valid within 60 cycles", name);
    end
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] exp);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (req_ready != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s: no req_ready within 60 cycles", name);
    end else begin
      chk(name, req_ready, exp);
    end
  endtask

  task automatic resp_case(input string name, input int exp_idx, input logic [W-1:0] exp_data,
                           input logic exp_err);
    int idx;
    wait_resp(name, idx);
    if (idx >= 0) begin
      chk({name, "_owner"}, idx, exp_idx);
      chk({name, "_data"}, resp_data, exp_data);
      chk({name, "_err"}, resp_err, exp_err);
    end
  endtask

  task automatic drain_resp();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (resp_valid == '0) break;
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int start_cnt;
    int cyc;
    // Both requesters valid from reset
    post(0, 5'd1, 32'd10, 32'd3);
    post(1, 5'd0, 32'd5, 32'd7);
    #12;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    @(posedge clock);
    #2 reset = 1'b0;

    resp_case("cont_r0", 0, 32'd7, 1'b0);
    resp_case("cont_r1", 1, 32'd12, 1'b0);
    post(0, 5'd3, 32'h0000_000A, 32'h0000_0005);
    post(1, 5'd1, 32'd0, 32'd1);
    resp_case("rot_r0", 0, 32'h0000_000F, 1'b0);
    resp_case("rot_r1", 1, 32'hFFFF_FFFF, 1'b0);

    // Single request: grant one cycle, response two cycles after
    post(0, 5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00);
    wait_grant("single_grant", 2'b01);
    @(negedge clock);
    chk("single_ready_drop", req_ready, 0);
    chk("single_no_resp_yet", resp_valid, 0);
    @(negedge clock);
    chk("single_resp_valid", resp_valid, 2'b01);
    chk("single_resp_data", resp_data, 32'hF000_F000);
    drain_resp();

    // Backpressure on requester 1 while requester 0 waits
    dir_rr = 2'b01;
    post(1, 5'd0, 32'h7FFF_FFFF, 32'd1);
    resp_case("bp_r1", 1, 32'h8000_0000, 1'b0);
    post(0, 5'd0, 32'd1, 32'd2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("bp_resp_valid", resp_valid, 2'b10);
      chk("bp_resp_data", resp_data, 32'h8000_0000);
      chk("bp_req_ready0", req_ready, 0);
    end
    dir_rr = '1;
    drain_resp();
    resp_case("bp_r0", 0, 32'd3, 1'b0);

    // Illegal opcode on requester 1, then pointer must favour requester 0
    post(1, 5'b01111, 32'h0000_1234, 32'h0000_5678);
    resp_case("illegal_r1", 1, 32'd0, 1'b1);
    post(0, 5'd0, 32'd1, 32'd1);
    post(1, 5'd0, 32'd2, 32'd2);
    resp_case("post_illegal_r0", 0, 32'd2, 1'b0);
    resp_case("post_illegal_r1", 1, 32'd4, 1'b0);

    // Move pointer to 1, then reset while requester 1 is in EXEC
    post(0, 5'd4, 32'd1, 32'd4);
    resp_case("sll_r0", 0, 32'h0000_0010, 1'b0);
    post(1, 5'd5, 32'h8000_0000, 32'd4);
    wait_grant("rst_mid_grant", 2'b10);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_req_ready", req_ready, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    chk("rstmid_resp_data", resp_data, 0);
    chk("rstmid_resp_err", resp_err, 0);
    chk("rstmid_alu_op", alu_op, 0);
    chk("rstmid_alu_a", alu_a, 0);
    chk("rstmid_alu_b", alu_b, 0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("rstmid_no_resp", resp_valid, 0);
    end
    post(0, 5'd0, 32'd3, 32'd4);
    post(1, 5'd0, 32'd5, 32'd6);
    wait_grant("rstmid_ptr0", 2'b01);
    resp_case("rstmid_r0", 0, 32'd7, 1'b0);
    resp_case("rstmid_r1", 1, 32'd11, 1'b0);

    // Random traffic against the model
    start_cnt = done_cnt;
    rand_mode = 1'b1;
    cyc = 0;
    while (done_cnt - start_cnt < 1000 && cyc < 40000) begin
      @(negedge clock);
      cyc++;
    end
    if (done_cnt - start_cnt < 1000) begin
      checks++;
      failures++;
      $display("FAIL random_budget: completed %0d required 1000", done_cnt - start_cnt);
    end
    rand_mode = 1'b0;
    dir_rr = '1;
    cyc = 0;
    while ((req_valid != '0 || m_busy) && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    if (req_valid != '0 || m_busy) begin
      checks++;
      failures++;
      $display("FAIL drain: traffic still pending after 200 cycles");
    end
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
